// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_write_arbiter_pkg: FSM encodings and sizing helpers shared by the arbiter and the host-side parser
package fifo_write_arbiter_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester handshake plus FIFO write port as seen by the arbiter
interface fifo_write_arbiter_if
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_shift;
    logic [WIDTH-1:0]         fifo_data;
    logic                     fifo_full;
    logic                     busy;
    logic [IDW-1:0]           owner;
    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_shift, fifo_data, busy, owner
    );
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_shift, fifo_data, busy, owner
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// fifo_write_arbiter_rr_pick: rotating-priority picker, first set request above the last owner wins
module fifo_write_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any_req
);
    logic [IW-1:0] idx;
    // Scan farthest-first so the nearest requester above last overwrites the rest
    always_comb begin
        grant = last;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (req[idx]) grant = idx;
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: packet-atomic round-robin sharing of one FIFO write port,
// with an optional owner-ID header word in front of each packet
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int              NUM_REQ    = 4,
    parameter int              WIDTH      = 8,
    parameter bit              HEADER_EN  = 1'b1,
    parameter logic [WIDTH-1:0] HEADER_TAG = WIDTH'(8'hFF)
) (
    input logic clk,
    input logic rst_n,
    fifo_write_arbiter_if.slave bus
);
    localparam int IDW = id_width(NUM_REQ);
    logic [1:0]       state;
    logic [IDW-1:0]   owner;
    logic [IDW-1:0]   pick;
    logic             any_req;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    fifo_write_arbiter_rr_pick #(.N(NUM_REQ), .IW(IDW)) u_rr_pick (
        .req     (bus.req_valid),
        .last    (owner),
        .grant   (pick),
        .any_req (any_req)
    );
    always_comb begin
        sel_valid = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = state == ST_DATA && !bus.fifo_full && owner == IDW'(i);
            if (owner == IDW'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last = bus.req_last[i];
                sel_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end
    assign bus.fifo_shift = !bus.fifo_full && (state == ST_HDR || (state == ST_DATA && sel_valid));
    assign bus.fifo_data = state == ST_HDR ? {HEADER_TAG[WIDTH-IDW-1:0], owner} :
                           state == ST_DATA ? sel_data : '0;
    assign bus.busy = state != ST_IDLE;
    assign bus.owner = owner;
    // The unused encoding falls back to IDLE so a corrupted state cannot lock the port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= IDW'(NUM_REQ - 1);
        end else if (state == ST_IDLE) begin
            if (any_req) begin
                owner <= pick;
                state <= HEADER_EN ? ST_HDR : ST_DATA;
            end
        end else if (state == ST_HDR) begin
            if (!bus.fifo_full) state <= ST_DATA;
        end else if (state != ST_DATA || (bus.fifo_shift && sel_last)) begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scoreboard bench, per-requester word order checked on every fifo_shift
module tb_fifo_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic do_rst = 1'b1;
    always #5 clk = ~clk;
    fifo_write_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) a ();
    fifo_write_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) b ();
    fifo_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .HEADER_EN(1'b1), .HEADER_TAG(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .bus(a.slave));
    fifo_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .HEADER_EN(1'b0), .HEADER_TAG(8'hFF)) dut_nh (
        .clk(clk), .rst_n(rst_n), .bus(b.slave));
    int total = 0;
    int bad = 0;
    logic [8:0] src_q [4][$];
    logic [8:0] exp_q [4][$];
    logic [7:0] hdr_exp [$];
    int cur = -1;
    int nshift = 0;
    logic full = 1'b0;
    logic [3:0] hold = 4'b0;
    logic [3:0] b_valid = 4'b0;
    logic [3:0] b_last = 4'b0;
    logic [31:0] b_data = 32'b0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask
    task automatic score(input logic [7:0] w);
        logic [8:0] e;
        nshift++;
        if (cur < 0) begin
            if (hdr_exp.size() == 0) chk("hdr_pending", hdr_exp.size(), 1);
            else begin
                chk("hdr", w, hdr_exp.pop_front());
                cur = int'(w[1:0]);
            end
        end else if (exp_q[cur].size() == 0) begin
            chk("data_pending", exp_q[cur].size(), 1);
        end else begin
            e = exp_q[cur].pop_front();
            chk($sformatf("data_r%0d", cur), w, e[7:0]);
            if (e[8]) cur = -1;
        end
    endtask
    // Inputs change only at negedge; outputs are sampled 1ns later, well before the next posedge
    task automatic tick();
        @(negedge clk);
        rst_n = !do_rst;
        a.fifo_full = full;
        for (int i = 0; i < 4; i++) begin
            a.req_valid[i] = src_q[i].size() > 0 && !hold[i];
            a.req_data[i*8 +: 8] = src_q[i].size() > 0 ? src_q[i][0][7:0] : 8'h00;
            a.req_last[i] = src_q[i].size() > 0 && src_q[i][0][8];
        end
        b.req_valid = b_valid;
        b.req_last = b_last;
        b.req_data = b_data;
        b.fifo_full = 1'b0;
        #1;
        chk("shift_while_full", 32'(a.fifo_shift && a.fifo_full), 0);
        if (a.fifo_shift === 1'b1) score(a.fifo_data);
        for (int i = 0; i < 4; i++)
            if (a.req_valid[i] && a.req_ready[i]) void'(src_q[i].pop_front());
    endtask
    function automatic int pending();
        int s = hdr_exp.size();
        for (int i = 0; i < 4; i++) s += src_q[i].size() + exp_q[i].size();
        return s;
    endfunction
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (n < budget && (pending() > 0 || a.busy !== 1'b0)) begin
            tick();
            n++;
        end
        chk(tag, pending() + 32'(a.busy), 0);
    endtask
    task automatic push_pkt(input int r, input logic [7:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            src_q[r].push_back({k == len - 1, base + 8'(k)});
            exp_q[r].push_back({k == len - 1, base + 8'(k)});
        end
    endtask
    task automatic do_reset();
        do_rst = 1'b1;
        tick();
        tick();
        do_rst = 1'b0;
        cur = -1;
    endtask
    task automatic wait_shifts(input string tag, input int target);
        int n = 0;
        while (n < 30 && nshift < target) begin
            tick();
            n++;
        end
        chk(tag, nshift, target);
    endtask
    initial begin
        int s;
        bit found;
        do_reset();
        chk("rst_busy", a.busy, 0);
        chk("rst_owner", a.owner, 3);
        chk("rst_ready", a.req_ready, 0);
        chk("rst_shift", a.fifo_shift, 0);
        chk("rst_data", a.fifo_data, 0);
        chk("rst_owner_nh", b.owner, 3);
        // single requester, three-word packet behind header 0xFE
        push_pkt(2, 8'h10, 3);
        hdr_exp.push_back(8'hFE);
        found = 0;
        for (int n = 0; n < 30 && !found; n++) begin
            tick();
            if (a.fifo_shift && a.fifo_data == 8'h12) begin
                chk("t1_busy_at_last", a.busy, 1);
                tick();
                chk("t1_busy_after", a.busy, 0);
                found = 1;
            end
        end
        chk("t1_last_seen", found, 1);
        drain("t1_drain", 10);
        // headerless instance: one-word packet, then next grant above requester 0
        b_valid = 4'b0001; b_last = 4'b0001; b_data = 32'h0000_00A5;
        tick();
        chk("t5_idle_noshift", b.fifo_shift, 0);
        tick();
        chk("t5_shift", b.fifo_shift, 1);
        chk("t5_data", b.fifo_data, 8'hA5);
        chk("t5_ready", b.req_ready, 4'b0001);
        b_valid = 4'b1010; b_last = 4'b1010; b_data = 32'hC300_5A00;
        tick();
        chk("t5_back_idle", b.busy, 0);
        chk("t5_idle_data", b.fifo_data, 0);
        tick();
        chk("t5_owner", b.owner, 1);
        chk("t5_shift2", b.fifo_shift, 1);
        chk("t5_data2", b.fifo_data, 8'h5A);
        b_valid = 4'b0; b_last = 4'b0;
        tick();
        chk("t5_idle2", b.busy, 0);
        // all requesters busy: strict rotation 0xFC..0xFF twice
        do_reset();
        for (int r = 0; r < 4; r++) begin
            push_pkt(r, 8'(8'h20 + 16 * r), 2);
            push_pkt(r, 8'(8'h28 + 16 * r), 2);
        end
        for (int k = 0; k < 8; k++) hdr_exp.push_back(8'(8'hFC + (k % 4)));
        drain("t2_drain", 80);
        // FIFO full for five cycles mid-packet
        push_pkt(0, 8'h60, 6);
        hdr_exp.push_back(8'hFC);
        wait_shifts("t3_start", nshift + 3);
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_noshift", a.fifo_shift, 0);
            chk("t3_noready", a.req_ready, 0);
            chk("t3_busy", a.busy, 1);
        end
        full = 1'b0;
        drain("t3_drain", 30);
        // owner bubbles while requester 1 waits
        s = nshift;
        push_pkt(3, 8'h80, 4);
        hdr_exp.push_back(8'hFF);
        wait_shifts("t4_start", s + 2);
        chk("t4_grant", a.owner, 3);
        push_pkt(1, 8'h90, 2);
        hdr_exp.push_back(8'hFD);
        hold[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_stall", a.fifo_shift, 0);
            chk("t4_held", a.owner, 3);
            chk("t4_busy", a.busy, 1);
        end
        hold[3] = 1'b0;
        drain("t4_drain", 40);
        // reset mid-packet abandons it and restarts from owner 3
        push_pkt(2, 8'hB0, 4);
        hdr_exp.push_back(8'hFE);
        wait_shifts("t6_start", nshift + 2);
        do_rst = 1'b1;
        tick();
        do_rst = 1'b0;
        src_q[2].delete();
        exp_q[2].delete();
        cur = -1;
        tick();
        chk("t6_owner", a.owner, 3);
        chk("t6_busy", a.busy, 0);
        chk("t6_shift", a.fifo_shift, 0);
        chk("t6_data", a.fifo_data, 0);
        chk("t6_ready", a.req_ready, 0);
        push_pkt(2, 8'hC0, 1);
        push_pkt(0, 8'hD0, 1);
        hdr_exp.push_back(8'hFC);
        hdr_exp.push_back(8'hFE);
        drain("t6_drain", 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
